video_pattern_gen: RTL
======================

// Module: video_pattern_gen
// PURPOSE
// Parametrised successor to the fixed DVI colour-bar generator. Streams one 24-bit RGB pixel per
// accepted transfer over a ready/valid interface, raster order, H_ACTIVE x V_ACTIVE per frame.
// Run-time mode select (stripes/solid/ramp/checker), configurable geometry, and page-alternating
// palettes. Sits between the frame-level control logic and the DVI/video output FIFO.
// PARAMETERS
// H_ACTIVE         800  pixels per line (>=2)
// V_ACTIVE         600  lines per frame (>=1)
// STRIPE_W         80   pixels per vertical stripe (>=1)
// BAND_H           50   lines per horizontal band (>=1)
// FRAMES_PER_PAGE  60   frames before palette page toggles (>=1)
// PORTS
// Clock         in   1   system clock, all logic on rising edge
// Reset         in   1   synchronous, active-high
// Enable        in   1   run request, sampled only in IDLE / at frame boundary
// Mode          in   2   0 stripes, 1 solid, 2 grey ramp, 3 checker; latched at frame start
// VideoReady    in   1   downstream can accept pixel
// VideoValid    out  1   Video holds a valid pixel
// Video         out  24  {R[7:0],G[7:0],B[7:0]}
// StartOfFrame  out  1   qualifies pixel (x=0,y=0)
// EndOfLine     out  1   qualifies pixel x=H_ACTIVE-1
// PageIndex     out  1   current palette page
// BEHAVIOUR
// Reset values: VideoValid=0, Video=0, StartOfFrame=0, EndOfLine=0, PageIndex=0; FSM=IDLE;
//   x,y,stripe/band subcounters, frame counter = 0; latched mode = 0. Reset mid-frame aborts the frame.
// FSM: IDLE -> ACTIVE when Enable=1 (latch Mode); VideoValid=1 with pixel (0,0) next cycle.
//   ACTIVE -> ACTIVE on frame end if Enable=1 (re-latch Mode, continue with no bubble);
//   ACTIVE -> IDLE on frame end if Enable=0. Enable low mid-frame has no effect until frame end.
// Handshake: transfer = VideoValid & VideoReady. On transfer, the next pixel is registered the same edge
//   (full throughput, 1 pixel/cycle). While VideoValid & !VideoReady, Video/SOF/EOL are held bit-stable.
//   VideoValid never drops mid-frame.
// Counters advance only on transfer. x wraps at H_ACTIVE-1 -> 0 with y+1; y wraps at V_ACTIVE-1 -> frame end.
//   Stripe subcounter wraps at STRIPE_W-1 and toggles stripe bit s; it also clears at line end.
//   Band subcounter wraps at BAND_H-1 and toggles band bit b; it also clears at frame end. No dividers.
// Frame end: frame counter +1; at FRAMES_PER_PAGE-1 it wraps to 0 and PageIndex toggles.
// Palettes (page0 / page1), entries 0..3:
//   page0: 8e44ad 2c3e50 16a085 2980b9
//   page1: 1abc9c e67e22 f1c40f 2ecc71
// Pixel colour:
//   Mode0 (stripes): entry {b,s}.
//   Mode1 (solid): entry 0.
//   Mode2 (ramp): {x[7:0],x[7:0],x[7:0]}, palette ignored.
//   Mode3 (checker): entry {1'b0, b^s}.
// StartOfFrame=1 only with pixel (0,0); EndOfLine=1 only with x=H_ACTIVE-1; both 0 when VideoValid=0.
// TESTING (small params: H=8 V=4 STRIPE_W=2 BAND_H=2 FPP=2 unless noted; VideoReady=1 unless noted)
// 1. Reset, Enable=1, Mode=0 -> line0: 8e44ad x2, 2c3e50 x2, repeat; line2: 16a085/2980b9; SOF on
//    pixel 0 only, EOL every 8th transfer.
// 2. Hold VideoReady=0 for 5 cycles mid-line (x=3) -> Video/EOL unchanged and VideoValid=1 throughout;
//    resume -> x=4 pixel with no skip or repeat.
// 3. Run 2 frames -> PageIndex 0->1 after 64 transfers; frame 3 line0 = 1abc9c/e67e22, line2 = f1c40f/2ecc71.
// 4. Change Mode 0->3 mid-frame -> current frame stays stripes; next frame checker: line0 8e44ad,2c3e50
//    alternating per 2 px, line2 phase inverted.
// 5. Mode=2, H=300 -> x=255 gives ffffff, x=256 gives 000000.
// 6. Reset asserted at x=5,y=1 -> next cycle VideoValid=0 and PageIndex=0; Enable still 1 -> restart at
//    (0,0) with SOF=1.
// 7. Enable dropped mid-frame -> frame completes (32 transfers), then VideoValid=0, FSM IDLE.

Source files
------------

// File: rtl/video_pattern_gen.sv
// ============================================================================
// Module   : video_pattern_gen
// Brief    : Ready/valid RGB test-pattern source with run-time mode and paged palettes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_pattern_gen #(
   parameter int H_ACTIVE        = 800,
   parameter int V_ACTIVE        = 600,
   parameter int STRIPE_W        = 80,
   parameter int BAND_H          = 50,
   parameter int FRAMES_PER_PAGE = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   input  logic [1:0]  i_mode,
   input  logic        i_video_ready,
   output logic        o_video_valid,
   output logic [23:0] o_video,
   output logic        o_start_of_frame,
   output logic        o_end_of_line,
   output logic        o_page_index
);

   localparam int c_XW = (H_ACTIVE > 1)        ? $clog2(H_ACTIVE)        : 1;
   localparam int c_YW = (V_ACTIVE > 1)        ? $clog2(V_ACTIVE)        : 1;
   localparam int c_SW = (STRIPE_W > 1)        ? $clog2(STRIPE_W)        : 1;
   localparam int c_BW = (BAND_H > 1)          ? $clog2(BAND_H)          : 1;
   localparam int c_FW = (FRAMES_PER_PAGE > 1) ? $clog2(FRAMES_PER_PAGE) : 1;

   localparam logic [c_XW-1:0] c_X_LAST  = c_XW'(H_ACTIVE - 1);
   localparam logic [c_YW-1:0] c_Y_LAST  = c_YW'(V_ACTIVE - 1);
   localparam logic [c_SW-1:0] c_SC_LAST = c_SW'(STRIPE_W - 1);
   localparam logic [c_BW-1:0] c_BC_LAST = c_BW'(BAND_H - 1);
   localparam logic [c_FW-1:0] c_F_LAST  = c_FW'(FRAMES_PER_PAGE - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   state_t            r_state;
   logic [1:0]        r_mode;
   logic [c_XW-1:0]   r_x;
   logic [c_YW-1:0]   r_y;
   logic [c_SW-1:0]   r_sc;
   logic [c_BW-1:0]   r_bc;
   logic [c_FW-1:0]   r_frame;
   logic              r_s, r_b, r_page;
   logic              r_valid, r_sof, r_eol;
   logic [23:0]       r_video;

   logic              w_xfer, w_last_x, w_last_y, w_frame_end;
   logic [c_XW-1:0]   w_nx;
   logic [c_YW-1:0]   w_ny;
   logic [c_SW-1:0]   w_nsc;
   logic [c_BW-1:0]   w_nbc;
   logic [c_FW-1:0]   w_nframe;
   logic              w_ns, w_nb, w_npage;
   logic [1:0]        w_nmode;
   logic [7:0]        w_nx8;
   logic [23:0]       w_next_px;

   function automatic logic [23:0] f_palette(input logic page, input logic [1:0] idx);
      case ({page, idx})
         3'b000:  return 24'h8e44ad;
         3'b001:  return 24'h2c3e50;
         3'b010:  return 24'h16a085;
         3'b011:  return 24'h2980b9;
         3'b100:  return 24'h1abc9c;
         3'b101:  return 24'he67e22;
         3'b110:  return 24'hf1c40f;
         default: return 24'h2ecc71;
      endcase
   endfunction

   function automatic logic [23:0] f_pixel(input logic [1:0] mode, input logic page,
                                           input logic s, input logic b, input logic [7:0] x8);
      case (mode)
         2'd0:    return f_palette(page, {b, s});
         2'd1:    return f_palette(page, 2'b00);
         2'd2:    return {x8, x8, x8};
         default: return f_palette(page, {1'b0, b ^ s});
      endcase
   endfunction

   assign w_xfer      = r_valid & i_video_ready;
   assign w_last_x    = (r_x == c_X_LAST);
   assign w_last_y    = (r_y == c_Y_LAST);
   assign w_frame_end = w_xfer & w_last_x & w_last_y;

   // Next raster position and stripe/band phase, counted rather than divided.
   always_comb begin
      w_nx  = r_x;
      w_ny  = r_y;
      w_nsc = r_sc;
      w_ns  = r_s;
      w_nbc = r_bc;
      w_nb  = r_b;
      if (w_xfer) begin
         if (w_last_x) begin
            w_nx  = '0;
            w_nsc = '0;
            w_ns  = 1'b0;
            if (w_last_y) begin
               w_ny  = '0;
               w_nbc = '0;
               w_nb  = 1'b0;
            end else begin
               w_ny = r_y + 1'b1;
               if (r_bc == c_BC_LAST) begin
                  w_nbc = '0;
                  w_nb  = ~r_b;
               end else begin
                  w_nbc = r_bc + 1'b1;
               end
            end
         end else begin
            w_nx = r_x + 1'b1;
            if (r_sc == c_SC_LAST) begin
               w_nsc = '0;
               w_ns  = ~r_s;
            end else begin
               w_nsc = r_sc + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_nframe = r_frame;
      w_npage  = r_page;
      if (w_frame_end) begin
         if (r_frame == c_F_LAST) begin
            w_nframe = '0;
            w_npage  = ~r_page;
         end else begin
            w_nframe = r_frame + 1'b1;
         end
      end
   end

   generate
      if (c_XW >= 8) begin : g_x8_wide
         assign w_nx8 = w_nx[7:0];
      end else begin : g_x8_narrow
         assign w_nx8 = {{(8 - c_XW){1'b0}}, w_nx};
      end
   endgenerate

   // Mode is taken live only for the first pixel of a frame.
   assign w_nmode   = ((r_state == S_IDLE) || w_frame_end) ? i_mode : r_mode;
   assign w_next_px = f_pixel(w_nmode, w_npage, w_ns, w_nb, w_nx8);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mode  <= 2'd0;
         r_x     <= '0;
         r_y     <= '0;
         r_sc    <= '0;
         r_bc    <= '0;
         r_s     <= 1'b0;
         r_b     <= 1'b0;
         r_frame <= '0;
         r_page  <= 1'b0;
         r_valid <= 1'b0;
         r_video <= 24'd0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_enable) begin
                  r_state <= S_ACTIVE;
                  r_mode  <= i_mode;
                  r_valid <= 1'b1;
                  r_video <= w_next_px;
                  r_sof   <= 1'b1;
                  r_eol   <= (w_nx == c_X_LAST);
               end
            end
            default: begin
               if (w_xfer) begin
                  r_x     <= w_nx;
                  r_y     <= w_ny;
                  r_sc    <= w_nsc;
                  r_bc    <= w_nbc;
                  r_s     <= w_ns;
                  r_b     <= w_nb;
                  r_frame <= w_nframe;
                  r_page  <= w_npage;
                  if (w_frame_end && !i_enable) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                     r_video <= 24'd0;
                     r_sof   <= 1'b0;
                     r_eol   <= 1'b0;
                  end else begin
                     r_mode  <= w_nmode;
                     r_valid <= 1'b1;
                     r_video <= w_next_px;
                     r_sof   <= w_frame_end;
                     r_eol   <= (w_nx == c_X_LAST);
                  end
               end
            end
         endcase
      end
   end

   assign o_video_valid    = r_valid;
   assign o_video          = r_video;
   assign o_start_of_frame = r_sof;
   assign o_end_of_line    = r_eol;
   assign o_page_index     = r_page;

endmodule

`default_nettype wire
